hier_poll_sched: RTL and testbench

Sequences a binary tree of 2**LEVELS parameterised leaf units that share one report bus, polling each leaf in turn. Leaves are polled in path order: leaf index bit LEVELS-1 selects the top-level branch (0 = x1, 1 = x2), down to bit 0 for the last level. For each leaf the block asserts a one-hot select plus request, waits for that leaf's acknowledge (or a timeout), and emits the captured word tagged with its leaf index. It sits between the leaf tree and a single result consumer (logger/checker).

---
 rtl/hier_poll_pkg.sv | 16 +
 rtl/hier_poll_sched_if.sv | 27 ++
 rtl/hier_poll_sched_poll_timer.sv | 25 ++
 rtl/hier_poll_sched.sv | 92 +++++++++
 tb/tb_hier_poll_sched.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_poll_pkg.sv
// Shared types and default sizing for the hierarchical leaf poll scheduler.
package hier_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_LEVELS  = 5;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 15;
    localparam int DEF_ERRW    = 8;

endpackage

// File: rtl/hier_poll_sched_if.sv
// Leaf report bus plus tagged result stream between scheduler, leaf tree and consumer.
interface hier_poll_sched_if #(
    parameter int LEVELS = 5,
    parameter int DW     = 32
);
    localparam int N = 2 ** LEVELS;

    logic [N-1:0]      sel;
    logic              req;
    logic              ack;
    logic [DW-1:0]     rdata;
    logic              out_valid;
    logic [LEVELS-1:0] out_idx;
    logic [DW-1:0]     out_data;
    logic              out_timeout;

    modport master (
        output sel, req, out_valid, out_idx, out_data, out_timeout,
        input  ack, rdata
    );

    modport slave (
        input  sel, req, out_valid, out_idx, out_data, out_timeout,
        output ack, rdata
    );

endinterface

// File: rtl/hier_poll_sched_poll_timer.sv
// Per-leaf wait counter: cleared between leaves, expires on its TIMEOUT-th enabled cycle.
module poll_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/hier_poll_sched.sv
// Polls every leaf of a 2**LEVELS tree in index order over one shared report bus.
module hier_poll_sched
    import hier_poll_pkg::*;
#(
    parameter int LEVELS  = DEF_LEVELS,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ERRW    = DEF_ERRW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [ERRW-1:0] err_count,
    hier_poll_sched_if.master bus
);
    localparam int N = 2 ** LEVELS;

    state_t            state_q;
    state_t            state_d;
    logic [LEVELS-1:0] idx_q;
    logic              expire;
    logic              last_leaf;

    assign last_leaf = (idx_q == LEVELS'(N - 1));

    poll_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != REQ),
        .en     (state_q == REQ),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = REQ;
            REQ:  if (bus.ack || expire) state_d = EMIT;
            EMIT: state_d = last_leaf ? DONE : REQ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leaf index, capture register and saturating timeout tally
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q           <= '0;
            bus.out_data    <= '0;
            bus.out_timeout <= 1'b0;
            err_count       <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                idx_q <= '0;
            end else if (state_q == EMIT && !last_leaf) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == REQ) begin
                if (bus.ack) begin
                    bus.out_data    <= bus.rdata;
                    bus.out_timeout <= 1'b0;
                end else if (expire) begin
                    bus.out_data    <= '0;
                    bus.out_timeout <= 1'b1;
                    if (err_count != {ERRW{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        bus.req       = (state_q == REQ);
        bus.sel       = bus.req ? (N'(1) << idx_q) : '0;
        bus.out_valid = (state_q == EMIT);
        bus.out_idx   = idx_q;
    end

endmodule

// File: tb/tb_hier_poll_sched.sv
// Directed bench for hier_poll_sched: a configurable leaf model plus a small saturation instance.
module tb_hier_poll_sched;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        to;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;
    logic busy, done, busy2, done2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic force_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int e0 = 0;
    int done_cnt = 0;
    int done_at = 0;
    int done2_cnt = 0;
    int sel20_cnt = 0;
    int wcnt = 0;
    int lidx;
    int delay [32];
    res_t res[$];
    res_t res2[$];

    hier_poll_sched_if #(.LEVELS(5), .DW(32)) bus ();
    hier_poll_sched_if #(.LEVELS(2), .DW(8))  bus2 ();

    hier_poll_sched #(.LEVELS(5), .DW(32), .TIMEOUT(15), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .err_count(err_count), .bus(bus)
    );

    hier_poll_sched #(.LEVELS(2), .DW(8), .TIMEOUT(3), .ERRW(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .err_count(err_count2), .bus(bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecount <= ecount + 1;
        wcnt   <= bus.req ? wcnt + 1 : 0;
    end

    // Leaf model: leaf i answers 2*i+1 after delay[i] REQ cycles; negative delay never answers
    always_comb begin
        lidx = 0;
        for (int i = 0; i < 32; i++) if (bus.sel[i]) lidx = i;
        bus.rdata = 32'(2 * lidx + 1);
        bus.ack   = (bus.req && delay[lidx] >= 0 && wcnt == delay[lidx]) || force_ack;
    end

    assign bus2.ack   = 1'b0;
    assign bus2.rdata = 8'hAA;

    always @(negedge clk) begin
        if (bus.out_valid) res.push_back('{int'(bus.out_idx), bus.out_data, bus.out_timeout});
        if (bus2.out_valid) res2.push_back('{int'(bus2.out_idx), 32'(bus2.out_data), bus2.out_timeout});
        if (done) begin
            done_cnt = done_cnt + 1;
            done_at  = ecount;
        end
        if (done2) done2_cnt = done2_cnt + 1;
        if (bus.req && bus.sel == 32'h20) sel20_cnt = sel20_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = ecount;
        start = 1'b0;
        res.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_delays(input int v);
        for (int i = 0; i < 32; i++) delay[i] = v;
    endtask

    initial begin
        bit ok;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        set_delays(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", bus.req, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_timeout", bus.out_timeout, 0);
        check("rst_err", err_count, 0);
        check("rst_err2", err_count2, 0);

        // Zero-wait pass
        start_pass();
        check("t1_busy", busy, 1);
        check("t1_sel0", bus.sel, 32'h1);
        wait_done(200, ok);
        check("t1_done_seen", ok, 1);
        check("t1_done_cycle", done_at - e0 + 1, 65);
        check("t1_count", res.size(), 32);
        for (int i = 0; i < res.size(); i++) begin
            check($sformatf("t1_idx%0d", i), res[i].idx, i);
            check($sformatf("t1_data%0d", i), res[i].data, 2 * i + 1);
            check($sformatf("t1_to%0d", i), res[i].to, 0);
        end
        check("t1_err", err_count, 0);
        @(negedge clk);
        check("t1_idle", busy, 0);

        // Leaf 5 silent
        set_delays(0);
        delay[5] = -1;
        sel20_cnt = 0;
        start_pass();
        wait_done(400, ok);
        check("t2_done_seen", ok, 1);
        check("t2_done_cycle", done_at - e0 + 1, 79);
        check("t2_count", res.size(), 32);
        check("t2_sel20_cycles", sel20_cnt, 15);
        if (res.size() == 32) begin
            check("t2_idx5", res[5].idx, 5);
            check("t2_data5", res[5].data, 0);
            check("t2_to5", res[5].to, 1);
            check("t2_data4", res[4].data, 9);
            check("t2_to6", res[6].to, 0);
            check("t2_data6", res[6].data, 13);
        end
        check("t2_err", err_count, 1);

        // Leaf 3 answers on the last allowed cycle
        set_delays(0);
        delay[3] = 14;
        start_pass();
        wait_done(400, ok);
        check("t3_done_seen", ok, 1);
        check("t3_done_cycle", done_at - e0 + 1, 79);
        if (res.size() == 32) begin
            check("t3_data3", res[3].data, 7);
            check("t3_to3", res[3].to, 0);
        end
        check("t3_err", err_count, 1);

        // start held into REQ, spurious ack in EMIT, start during DONE
        set_delays(0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = ecount;
        res.delete();
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) break;
        end
        force_ack = 1'b1;
        @(negedge clk);
        #1;
        force_ack = 1'b0;
        wait_done(200, ok);
        check("t4_done_seen", ok, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_one_done", done_cnt - d0, 1);
        check("t4_count", res.size(), 32);
        if (res.size() > 1) check("t4_idx1", res[1].idx, 1);

        // Reset while polling leaf 10
        d0 = done_cnt;
        start_pass();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (bus.req && bus.sel == 32'h400) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_leaf10_seen", ok, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_req", bus.req, 0);
        check("t5_sel", bus.sel, 0);
        check("t5_err", err_count, 0);
        check("t5_out_valid", bus.out_valid, 0);
        repeat (5) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_still_idle", busy, 0);
        start_pass();
        wait_done(200, ok);
        check("t5_restart_done", ok, 1);
        check("t5_restart_count", res.size(), 32);
        if (res.size() > 0) check("t5_restart_idx0", res[0].idx, 0);

        // Saturation on a small tree with every leaf silent
        for (int p = 0; p < 2; p++) begin
            d0 = done2_cnt;
            res2.delete();
            @(negedge clk);
            start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                #1;
                if (done2_cnt != d0) begin
                    ok = 1'b1;
                    break;
                end
            end
            check($sformatf("t6_done%0d", p), ok, 1);
            check($sformatf("t6_count%0d", p), res2.size(), 4);
            if (res2.size() == 4) check($sformatf("t6_to%0d", p), res2[3].to, 1);
            check($sformatf("t6_err%0d", p), err_count2, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
